// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder sequencer.
// Holds the controller state encoding and the supported width ceiling.
// No logic lives here.
package serial_add_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   localparam int SA_MAX_WIDTH = 32;

endpackage

// File: rtl/FullAdder.sv
// Single-bit full adder, the only arithmetic element of the serial adder.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no handshake.
module FullAdder (
   input  logic InA,
   input  logic InB,
   input  logic Cin,
   output logic Sum,
   output logic CarryOut
);

   assign Sum      = InA ^ InB ^ Cin;
   assign CarryOut = (InA & InB) | (Cin & (InA ^ InB));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one shared FullAdder, LSB first, carry held in a flop.
// Latency: accept at edge N gives OutValid after edge N+WIDTH; one add per WIDTH+2 cycles.
// Backpressure: OutReady low parks the block in DONE with outputs frozen; InReady stays low.
// Optional signed-overflow flag is built only when SERIAL_ADD_OVF_EN is defined.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             InValid,
   output logic             InReady,
   input  logic [WIDTH-1:0] OpA,
   input  logic [WIDTH-1:0] OpB,
   input  logic             CinIn,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] Result,
   output logic             CarryOut,
   output logic             Overflow,
   output logic             Busy
);

   localparam int            CntW    = $clog2(WIDTH);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   if (WIDTH < 2 || WIDTH > SA_MAX_WIDTH) begin : gBadWidth
      $error("serial_add_ctrl: WIDTH out of range");
   end

   state_t            state;
   logic [WIDTH-1:0]  regA;
   logic [WIDTH-1:0]  regB;
   logic [WIDTH-1:0]  regSum;
   logic              carry;
   logic [CntW-1:0]   cnt;
   logic              faSum;
   logic              faCarry;
   logic              accept;
   logic              lastShift;

   assign accept    = (state == IDLE) && InValid && InReady;
   assign lastShift = (state == SHIFT) && (cnt == LastCnt);

   FullAdder uFullAdder (
      .InA      (regA[0]),
      .InB      (regB[0]),
      .Cin      (carry),
      .Sum      (faSum),
      .CarryOut (faCarry)
   );

   // Sequencer: load operands, shift one bit per cycle through the adder, hold result until taken.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state    <= IDLE;
         regA     <= '0;
         regB     <= '0;
         regSum   <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         InReady  <= 1'b0;
         OutValid <= 1'b0;
         Busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  regA    <= OpA;
                  regB    <= OpB;
                  carry   <= CinIn;
                  cnt     <= '0;
                  state   <= SHIFT;
                  InReady <= 1'b0;
                  Busy    <= 1'b1;
               end else begin
                  InReady <= 1'b1;
               end
            end
            SHIFT: begin
               regA   <= regA >> 1;
               regB   <= regB >> 1;
               regSum <= {faSum, regSum[WIDTH-1:1]};
               carry  <= faCarry;
               cnt    <= cnt + 1'b1;
               if (cnt == LastCnt) begin
                  state    <= DONE;
                  Busy     <= 1'b0;
                  OutValid <= 1'b1;
               end
            end
            DONE: begin
               if (OutReady) begin
                  state    <= IDLE;
                  OutValid <= 1'b0;
                  InReady  <= 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               InReady  <= 1'b0;
               OutValid <= 1'b0;
               Busy     <= 1'b0;
            end
         endcase
      end
   end

   // Sum and carry registers double as the result; they only change while shifting or loading.
   assign Result   = regSum;
   assign CarryOut = carry;

`ifdef SERIAL_ADD_OVF_EN
   logic ovfReg;

   // Signed overflow: carry into the MSB (the carry flop on the last shift) XOR carry out of it.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         ovfReg <= 1'b0;
      end else if (accept) begin
         ovfReg <= 1'b0;
      end else if (lastShift) begin
         ovfReg <= carry ^ faCarry;
      end
   end

   assign Overflow = ovfReg;
`else
   assign Overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed vector table on an 8-bit instance,
// hand-written hold/abort sequences, and an exhaustive sweep on a 4-bit instance.
// Overflow expectations follow SERIAL_ADD_OVF_EN.
module tb_serial_add_ctrl;

`ifdef SERIAL_ADD_OVF_EN
   localparam bit OvfOn = 1'b1;
`else
   localparam bit OvfOn = 1'b0;
`endif

   logic       Clk;
   logic       Rst_n;

   logic       inValid8, inReady8, cin8, outValid8, outReady8, co8, ovf8, busy8;
   logic [7:0] opA8, opB8, result8;

   logic       inValid4, inReady4, cin4, outValid4, outReady4, co4, ovf4, busy4;
   logic [3:0] opA4, opB4, result4;

   int checks;
   int errors;

   serial_add_ctrl #(.WIDTH(8)) dut8 (
      .Clk(Clk), .Rst_n(Rst_n),
      .InValid(inValid8), .InReady(inReady8),
      .OpA(opA8), .OpB(opB8), .CinIn(cin8),
      .OutValid(outValid8), .OutReady(outReady8),
      .Result(result8), .CarryOut(co8), .Overflow(ovf8), .Busy(busy8)
   );

   serial_add_ctrl #(.WIDTH(4)) dut4 (
      .Clk(Clk), .Rst_n(Rst_n),
      .InValid(inValid4), .InReady(inReady4),
      .OpA(opA4), .OpB(opB4), .CinIn(cin4),
      .OutValid(outValid4), .OutReady(outReady4),
      .Result(result4), .CarryOut(co4), .Overflow(ovf4), .Busy(busy4)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] r;
      logic       co;
      logic       ov;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive one operand set into dut8 (OutReady high) and collect the result and latency.
   task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       output logic [7:0] r, output logic co, output logic ov, output int lat);
      int t;
      t = 0;
      outReady8 = 1'b1;
      while (!inReady8 && t < 50) begin
         @(posedge Clk); #1;
         t++;
      end
      opA8 = a; opB8 = b; cin8 = cin; inValid8 = 1'b1;
      @(posedge Clk); #1;
      inValid8 = 1'b0;
      lat = 0;
      while (!outValid8 && lat < 50) begin
         @(posedge Clk); #1;
         lat++;
      end
      r  = result8;
      co = co8;
      ov = ovf8;
      @(posedge Clk); #1;
   endtask

   task automatic add4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                       output logic [4:0] sum, output int lat);
      int t;
      t = 0;
      outReady4 = 1'b1;
      while (!inReady4 && t < 50) begin
         @(posedge Clk); #1;
         t++;
      end
      opA4 = a; opB4 = b; cin4 = cin; inValid4 = 1'b1;
      @(posedge Clk); #1;
      inValid4 = 1'b0;
      lat = 0;
      while (!outValid4 && lat < 50) begin
         @(posedge Clk); #1;
         lat++;
      end
      sum = {co4, result4};
      @(posedge Clk); #1;
   endtask

   initial begin
      logic [7:0] r;
      logic       co;
      logic       ov;
      logic [4:0] sum4;
      logic [4:0] exp4;
      int         lat;
      int         t;
      bit         sawVld;

      checks = 0;
      errors = 0;

      vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
      vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[5] = '{8'hC8, 8'h64, 1'b1, 8'h2D, 1'b1, 1'b0};

      Rst_n = 1'b0;
      inValid8 = 1'b0; opA8 = '0; opB8 = '0; cin8 = 1'b0; outReady8 = 1'b1;
      inValid4 = 1'b0; opA4 = '0; opB4 = '0; cin4 = 1'b0; outReady4 = 1'b1;

      // Reset state
      repeat (3) @(posedge Clk);
      #1;
      check("rst_inready",  {31'b0, inReady8},  32'd0);
      check("rst_outvalid", {31'b0, outValid8}, 32'd0);
      check("rst_busy",     {31'b0, busy8},     32'd0);
      check("rst_result",   {24'b0, result8},   32'd0);
      check("rst_carry",    {31'b0, co8},       32'd0);
      check("rst_ovf",      {31'b0, ovf8},      32'd0);
      Rst_n = 1'b1;
      #1;
      check("rel_inready_low", {31'b0, inReady8}, 32'd0);
      @(posedge Clk); #1;
      check("rel_inready_high", {31'b0, inReady8}, 32'd1);

      // Directed vector table
      for (int i = 0; i < 6; i++) begin
         add8(vecs[i].a, vecs[i].b, vecs[i].cin, r, co, ov, lat);
         check($sformatf("vec%0d_result", i), {24'b0, r}, {24'b0, vecs[i].r});
         check($sformatf("vec%0d_carry", i), {31'b0, co}, {31'b0, vecs[i].co});
         check($sformatf("vec%0d_ovf", i), {31'b0, ov}, {31'b0, vecs[i].ov & OvfOn});
         check($sformatf("vec%0d_latency", i), lat, 32'd8);
      end

      // Backpressure hold with ignored InValid pulses in SHIFT and DONE
      outReady8 = 1'b0;
      opA8 = 8'h12; opB8 = 8'h34; cin8 = 1'b0; inValid8 = 1'b1;
      @(posedge Clk); #1;
      inValid8 = 1'b0;
      check("hold_busy", {31'b0, busy8}, 32'd1);
      opA8 = 8'hFF; opB8 = 8'hFF; cin8 = 1'b1; inValid8 = 1'b1;
      @(posedge Clk); #1;
      inValid8 = 1'b0;
      t = 0;
      while (!outValid8 && t < 20) begin
         @(posedge Clk); #1;
         t++;
      end
      check("hold_reach_done", {31'b0, outValid8}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         inValid8 = 1'b1;
         check("hold_result",   {24'b0, result8},   32'h46);
         check("hold_carry",    {31'b0, co8},       32'd0);
         check("hold_outvalid", {31'b0, outValid8}, 32'd1);
         check("hold_inready",  {31'b0, inReady8},  32'd0);
         @(posedge Clk); #1;
      end
      inValid8 = 1'b0;
      outReady8 = 1'b1;
      @(posedge Clk); #1;
      check("hs_outvalid_low", {31'b0, outValid8}, 32'd0);
      check("hs_inready_high", {31'b0, inReady8},  32'd1);
      @(posedge Clk); #1;
      check("hs_single_outvalid", {31'b0, outValid8}, 32'd0);
      check("hs_single_busy",     {31'b0, busy8},     32'd0);

      // Reset aborts an addition in its 4th SHIFT cycle
      opA8 = 8'hAA; opB8 = 8'h55; cin8 = 1'b0; inValid8 = 1'b1;
      @(posedge Clk); #1;
      inValid8 = 1'b0;
      repeat (3) begin
         @(posedge Clk); #1;
      end
      check("abort_busy_before", {31'b0, busy8}, 32'd1);
      Rst_n = 1'b0;
      #1;
      check("abort_inready",  {31'b0, inReady8},  32'd0);
      check("abort_outvalid", {31'b0, outValid8}, 32'd0);
      check("abort_busy",     {31'b0, busy8},     32'd0);
      check("abort_result",   {24'b0, result8},   32'd0);
      check("abort_carry",    {31'b0, co8},       32'd0);
      check("abort_ovf",      {31'b0, ovf8},      32'd0);
      @(negedge Clk);
      Rst_n = 1'b1;
      sawVld = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge Clk); #1;
         if (outValid8) sawVld = 1'b1;
      end
      check("abort_no_outvalid", {31'b0, sawVld}, 32'd0);
      add8(8'h10, 8'h20, 1'b0, r, co, ov, lat);
      check("post_abort_result",  {24'b0, r},  32'h30);
      check("post_abort_carry",   {31'b0, co}, 32'd0);
      check("post_abort_latency", lat,         32'd8);

      // Exhaustive 4-bit sweep
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            for (int c = 0; c < 2; c++) begin
               add4(4'(a), 4'(b), 1'(c), sum4, lat);
               exp4 = 5'(a + b + c);
               check($sformatf("exh_sum_%0d_%0d_%0d", a, b, c), {27'b0, sum4}, {27'b0, exp4});
               check($sformatf("exh_lat_%0d_%0d_%0d", a, b, c), lat, 32'd4);
            end
         end
      end
      check("exh_ovf_off_w4", {31'b0, ovf4 & ~OvfOn}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
